// File: rtl/rvfi_cover_pkg.sv
// Shared types and helpers for the RVFI cover run-control sequencer.
// State encoding, class indices and a width-parameterised saturating add.
package rvfi_cover_pkg;

  typedef enum logic [2:0] {
    ST_WARM  = 3'd0,
    ST_RUN   = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  localparam int NORM = 0;
  localparam int TRAP = 1;
  localparam int INTR = 2;

  // Adds a and b, clamping at 2^w-1 (w up to 32).
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w
  );
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/rvfi_class_counter.sv
// Saturating per-class retirement counter: popcount of NRET hit lines.
// Ports: clock, clear (sync), en, hits[NRET], count[CNT_W].
module rvfi_class_counter
  import rvfi_cover_pkg::*;
#(
  parameter int NRET  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             en,
  input  logic [NRET-1:0]  hits,
  output logic [CNT_W-1:0] count
);

  logic [31:0] inc;

  always_comb begin
    inc = '0;
    for (int i = 0; i < NRET; i++) begin
      inc = inc + 32'(hits[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= CNT_W'(sat_add(32'(count), inc, CNT_W));
    end
  end

endmodule

// File: rtl/rvfi_cover_sequencer.sv
// Run-control sequencer: warm-up, per-class goal counting, check strobe.
// Ports: clock, reset, rvfi_valid/trap/intr[NRET]; check, done, fail,
// phase[3], cnt_norm/cnt_trap/cnt_intr[CNT_W].
module rvfi_cover_sequencer
  import rvfi_cover_pkg::*;
#(
  parameter int NRET      = 1,
  parameter int CNT_W     = 8,
  parameter int WARMUP    = 4,
  parameter int NORM_GOAL = 8,
  parameter int TRAP_GOAL = 1,
  parameter int INTR_GOAL = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NRET-1:0]  rvfi_valid,
  input  logic [NRET-1:0]  rvfi_trap,
  input  logic [NRET-1:0]  rvfi_intr,
  output logic             check,
  output logic             done,
  output logic             fail,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] cnt_norm,
  output logic [CNT_W-1:0] cnt_trap,
  output logic [CNT_W-1:0] cnt_intr
);

  // WARM holds for WARMUP cycles (at least one, since reset lands here).
  localparam logic [CNT_W-1:0] WARM_LAST =
    (WARMUP > 0) ? CNT_W'(WARMUP - 1) : '0;
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0] NORM_G = 32'(NORM_GOAL);
  localparam logic [31:0] TRAP_G = 32'(TRAP_GOAL);
  localparam logic [31:0] INTR_G = 32'(INTR_GOAL);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] cyc_nxt;
  logic             goals_met;
  logic             run_en;

  logic [2:0][NRET-1:0]  hits;
  logic [2:0][CNT_W-1:0] cnt;

  assign hits[NORM] = rvfi_valid & ~rvfi_trap & ~rvfi_intr;
  assign hits[TRAP] = rvfi_valid & rvfi_trap;
  assign hits[INTR] = rvfi_valid & rvfi_intr;

  assign run_en = (state == ST_RUN);

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    rvfi_class_counter #(
      .NRET  (NRET),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clock (clock),
      .clear (reset),
      .en    (run_en),
      .hits  (hits[k]),
      .count (cnt[k])
    );
  end

  assign goals_met = (32'(cnt[NORM]) >= NORM_G)
                   && (32'(cnt[TRAP]) >= TRAP_G)
                   && (32'(cnt[INTR]) >= INTR_G);

  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc;
    unique case (state)
      ST_WARM: begin
        if (cyc == WARM_LAST) begin
          state_nxt = ST_RUN;
          cyc_nxt   = '0;
        end else begin
          cyc_nxt = cyc + CNT_W'(1);
        end
      end
      ST_RUN: begin
        // Goal completion takes priority over a coincident timeout.
        if (goals_met) begin
          state_nxt = ST_CHECK;
        end else if (cyc == RUN_LAST) begin
          state_nxt = ST_FAIL;
        end else begin
          cyc_nxt = cyc + CNT_W'(1);
        end
      end
      ST_CHECK: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      ST_FAIL:  state_nxt = ST_FAIL;
      default:  state_nxt = ST_WARM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_WARM;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      cyc   <= cyc_nxt;
    end
  end

  assign check    = (state == ST_CHECK);
  assign done     = (state == ST_DONE);
  assign fail     = (state == ST_FAIL);
  assign phase    = state;
  assign cnt_norm = cnt[NORM];
  assign cnt_trap = cnt[TRAP];
  assign cnt_intr = cnt[INTR];

endmodule

// File: tb/tb_rvfi_cover_sequencer.sv
// Self-checking bench for rvfi_cover_sequencer.
// Three configurations share one clock; each is reset independently.
module tb_rvfi_cover_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // A: NRET=1, WARMUP=4, all goals 0
  logic       a_reset;
  logic [0:0] a_valid, a_trap, a_intr;
  logic       a_check, a_done, a_fail;
  logic [2:0] a_phase;
  logic [7:0] a_norm, a_tr, a_in;

  // B: NRET=2, WARMUP=0, NORM=8, TRAP=1, INTR=0, TIMEOUT=64
  logic       b_reset;
  logic [1:0] b_valid, b_trap, b_intr;
  logic       b_check, b_done, b_fail;
  logic [2:0] b_phase;
  logic [7:0] b_norm, b_tr, b_in;

  // C: NRET=2, CNT_W=4, WARMUP=2, NORM=15, TRAP=1, TIMEOUT=10
  logic       c_reset;
  logic [1:0] c_valid, c_trap, c_intr;
  logic       c_check, c_done, c_fail;
  logic [2:0] c_phase;
  logic [3:0] c_norm, c_tr, c_in;

  rvfi_cover_sequencer #(
    .NRET(1), .CNT_W(8), .WARMUP(4), .NORM_GOAL(0),
    .TRAP_GOAL(0), .INTR_GOAL(0), .TIMEOUT(64)
  ) u_a (
    .clock(clk), .reset(a_reset),
    .rvfi_valid(a_valid), .rvfi_trap(a_trap), .rvfi_intr(a_intr),
    .check(a_check), .done(a_done), .fail(a_fail), .phase(a_phase),
    .cnt_norm(a_norm), .cnt_trap(a_tr), .cnt_intr(a_in)
  );

  rvfi_cover_sequencer #(
    .NRET(2), .CNT_W(8), .WARMUP(0), .NORM_GOAL(8),
    .TRAP_GOAL(1), .INTR_GOAL(0), .TIMEOUT(64)
  ) u_b (
    .clock(clk), .reset(b_reset),
    .rvfi_valid(b_valid), .rvfi_trap(b_trap), .rvfi_intr(b_intr),
    .check(b_check), .done(b_done), .fail(b_fail), .phase(b_phase),
    .cnt_norm(b_norm), .cnt_trap(b_tr), .cnt_intr(b_in)
  );

  rvfi_cover_sequencer #(
    .NRET(2), .CNT_W(4), .WARMUP(2), .NORM_GOAL(15),
    .TRAP_GOAL(1), .INTR_GOAL(0), .TIMEOUT(10)
  ) u_c (
    .clock(clk), .reset(c_reset),
    .rvfi_valid(c_valid), .rvfi_trap(c_trap), .rvfi_intr(c_intr),
    .check(c_check), .done(c_done), .fail(c_fail), .phase(c_phase),
    .cnt_norm(c_norm), .cnt_trap(c_tr), .cnt_intr(c_in)
  );

  typedef struct {
    logic [1:0] v;
    logic [1:0] t;
    logic [1:0] i;
    int         en;
    int         et;
    int         ei;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_to_run();
    b_reset = 1'b1;
    b_valid = '0; b_trap = '0; b_intr = '0;
    tick(); tick();
    b_reset = 1'b0;
    for (int i = 0; i < 20 && b_phase != 3'd1; i++) tick();
    chk("b_reach_run", int'(b_phase), 1);
  endtask

  // Reference model state for configuration B
  int m_ph, m_runs, m_age;
  int m_cnt [3];

  task automatic model_step(
    input logic [1:0] v, input logic [1:0] t, input logic [1:0] i
  );
    int nn, nt, ni;
    bit goals;
    nn = 0; nt = 0; ni = 0;
    for (int ch = 0; ch < 2; ch++) begin
      if (v[ch]) begin
        if (t[ch]) nt++;
        if (i[ch]) ni++;
        if (!t[ch] && !i[ch]) nn++;
      end
    end
    case (m_ph)
      0: begin
        m_age++;
        if (m_age >= 1) begin m_ph = 1; m_runs = 0; end
      end
      1: begin
        goals = (m_cnt[0] >= 8) && (m_cnt[1] >= 1) && (m_cnt[2] >= 0);
        m_cnt[0] = (m_cnt[0] + nn > 255) ? 255 : m_cnt[0] + nn;
        m_cnt[1] = (m_cnt[1] + nt > 255) ? 255 : m_cnt[1] + nt;
        m_cnt[2] = (m_cnt[2] + ni > 255) ? 255 : m_cnt[2] + ni;
        m_runs++;
        if (goals) m_ph = 2;
        else if (m_runs == 64) m_ph = 4;
      end
      2: m_ph = 3;
      default: ;
    endcase
  endtask

  task automatic model_cmp();
    chk("rnd_phase", int'(b_phase), m_ph);
    chk("rnd_check", int'(b_check), int'(m_ph == 2));
    chk("rnd_done", int'(b_done), int'(m_ph == 3));
    chk("rnd_fail", int'(b_fail), int'(m_ph == 4));
    chk("rnd_norm", int'(b_norm), m_cnt[0]);
    chk("rnd_trap", int'(b_tr), m_cnt[1]);
    chk("rnd_intr", int'(b_in), m_cnt[2]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [1:0] v, t, i;

    tbl[0] = '{2'b00, 2'b00, 2'b00, 0, 0, 0};
    tbl[1] = '{2'b01, 2'b01, 2'b01, 0, 1, 1};
    tbl[2] = '{2'b11, 2'b00, 2'b00, 2, 1, 1};
    tbl[3] = '{2'b10, 2'b00, 2'b10, 2, 1, 2};
    tbl[4] = '{2'b01, 2'b10, 2'b00, 3, 1, 2};
    tbl[5] = '{2'b11, 2'b00, 2'b00, 5, 1, 2};
    tbl[6] = '{2'b11, 2'b00, 2'b00, 7, 1, 2};
    tbl[7] = '{2'b01, 2'b00, 2'b00, 8, 1, 2};

    a_reset = 1'b1; a_valid = '0; a_trap = '0; a_intr = '0;
    b_reset = 1'b1; b_valid = '0; b_trap = '0; b_intr = '0;
    c_reset = 1'b1; c_valid = 2'b11; c_trap = '0; c_intr = '0;
    tick(); tick();

    // A: warm-up timing with all goals zero
    a_reset = 1'b0;
    chk("a_rst_phase", int'(a_phase), 0);
    chk("a_rst_check", int'(a_check), 0);
    chk("a_rst_done", int'(a_done), 0);
    chk("a_rst_fail", int'(a_fail), 0);
    chk("a_rst_norm", int'(a_norm), 0);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk($sformatf("a_check_c%0d", n), int'(a_check), int'(n == 5));
      chk($sformatf("a_done_c%0d", n), int'(a_done), int'(n >= 6));
      chk($sformatf("a_fail_c%0d", n), int'(a_fail), 0);
    end
    chk("a_cnt_norm", int'(a_norm), 0);
    chk("a_cnt_trap", int'(a_tr), 0);
    chk("a_cnt_intr", int'(a_in), 0);

    // B: four cycles of dual normal retires, then a trap on channel 1
    b_to_run();
    for (int k = 0; k < 4; k++) begin
      b_valid = 2'b11; b_trap = 2'b00;
      tick();
    end
    b_valid = 2'b10; b_trap = 2'b10;
    tick();
    b_valid = '0; b_trap = '0;
    chk("b_seq_norm", int'(b_norm), 8);
    chk("b_seq_trap", int'(b_tr), 1);
    chk("b_seq_phase", int'(b_phase), 1);
    tick();
    chk("b_seq_check", int'(b_check), 1);
    pulses = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (b_check) pulses++;
    end
    chk("b_seq_pulses", pulses, 1);
    chk("b_seq_done", int'(b_done), 1);
    chk("b_seq_fail", int'(b_fail), 0);
    chk("b_seq_norm_hold", int'(b_norm), 8);

    // B: table of classification vectors
    b_to_run();
    for (int r = 0; r < 8; r++) begin
      b_valid = tbl[r].v; b_trap = tbl[r].t; b_intr = tbl[r].i;
      tick();
      chk($sformatf("tbl%0d_norm", r), int'(b_norm), tbl[r].en);
      chk($sformatf("tbl%0d_trap", r), int'(b_tr), tbl[r].et);
      chk($sformatf("tbl%0d_intr", r), int'(b_in), tbl[r].ei);
      chk($sformatf("tbl%0d_phase", r), int'(b_phase), 1);
    end
    b_valid = '0; b_trap = '0; b_intr = '0;
    tick();
    chk("tbl_check", int'(b_check), 1);
    tick();
    chk("tbl_done", int'(b_done), 1);

    // B: reset in the middle of RUN with a retirement on the same edge
    b_to_run();
    b_valid = 2'b11; tick(); tick();
    b_valid = 2'b01; tick();
    chk("mid_norm5", int'(b_norm), 5);
    b_reset = 1'b1; b_valid = 2'b11;
    tick();
    chk("mid_phase", int'(b_phase), 0);
    chk("mid_norm", int'(b_norm), 0);
    chk("mid_trap", int'(b_tr), 0);
    chk("mid_intr", int'(b_in), 0);
    chk("mid_done", int'(b_done), 0);
    chk("mid_fail", int'(b_fail), 0);
    b_reset = 1'b0; b_valid = '0;
    tick();
    chk("mid_after_norm", int'(b_norm), 0);

    // C: saturation at 15 and timeout after 10 RUN cycles
    c_reset = 1'b0;
    for (int k = 0; k < 20 && c_phase != 3'd1; k++) tick();
    chk("c_reach_run", int'(c_phase), 1);
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("c_norm_r%0d", j), int'(c_norm),
          (2 * j > 15) ? 15 : 2 * j);
      chk($sformatf("c_phase_r%0d", j), int'(c_phase), (j < 10) ? 1 : 4);
      chk($sformatf("c_check_r%0d", j), int'(c_check), 0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("c_fail", int'(c_fail), 1);
      chk("c_done", int'(c_done), 0);
      chk("c_check", int'(c_check), 0);
      chk("c_norm_frozen", int'(c_norm), 15);
      chk("c_trap_frozen", int'(c_tr), 0);
    end

    // B: randomised episodes against the reference model
    for (int ep = 0; ep < 6; ep++) begin
      b_reset = 1'b1; b_valid = '0; b_trap = '0; b_intr = '0;
      tick(); tick();
      b_reset = 1'b0;
      m_ph = 0; m_runs = 0; m_age = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_cnt[2] = 0;
      model_cmp();
      for (int n = 0; n < 90; n++) begin
        v = 2'($urandom_range(0, 3));
        t = 2'b00;
        i = 2'b00;
        if (ep % 3 != 0 && $urandom_range(0, 15) == 0)
          t = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0)
          i = 2'($urandom_range(1, 3));
        b_valid = v; b_trap = t; b_intr = i;
        model_step(v, t, i);
        tick();
        model_cmp();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
